// File: rtl/multi_octave_storage.sv
// Multi-octave sample store: octave 0 takes every write, octave k every 2^k-th write.
// Optional macro DECIMATE_AVG_EN: decimated octaves take a two-sample average instead of dropping.
module multi_octave_storage #(
  parameter int N     = 16,
  parameter int OCT   = 5,
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [N-1:0]     newSample_i,
  input  logic                    writeSample_i,
  input  logic [$clog2(OCT)-1:0]  rdOctave_i,
  output logic signed [N-1:0]     sample0_o,
  output logic signed [N-1:0]     sample1_o,
  output logic signed [N-1:0]     oldestSample_o,
  output logic [OCT-1:0]          octWritten_o,
  output logic [OCT-1:0]          octFull_o
);

  localparam int OW = $clog2(OCT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = OCT - 1;

  typedef logic signed [N-1:0] sample_t;

  sample_t        mem_q   [OCT][DEPTH];
  logic [PW-1:0]  wrPtr_q [OCT];
  logic [CW-1:0]  decCnt_q;
  logic [CW-1:0]  decCnt_d;
  logic [OCT-1:0] fire_d;
  logic [OCT-1:0] octWritten_q;
  logic [OCT-1:0] octFull_q;
  sample_t        octIn_d [OCT];

  logic           rdValid;
  logic [OW-1:0]  rdIdx;
  logic [PW-1:0]  rdPtr;

  // decCnt_d is the write number w (mod 2^CW) of the write being accepted now
  always_comb begin
    decCnt_d = decCnt_q + CW'(1);
    fire_d   = '0;
    for (int k = 0; k < OCT; k++) begin
      fire_d[k] = writeSample_i && ((decCnt_d & CW'((1 << k) - 1)) == '0);
    end
  end

`ifdef DECIMATE_AVG_EN
  sample_t      vPrev;
  logic [N:0]   avgSum;
`endif

  always_comb begin
    octIn_d[0] = newSample_i;
`ifdef DECIMATE_AVG_EN
    vPrev  = '0;
    avgSum = '0;
`endif
    for (int k = 1; k < OCT; k++) begin
`ifdef DECIMATE_AVG_EN
      vPrev      = mem_q[k-1][wrPtr_q[k-1] - PW'(1)];
      avgSum     = {vPrev[N-1], vPrev} + {octIn_d[k-1][N-1], octIn_d[k-1]};
      octIn_d[k] = avgSum[N:1];
`else
      octIn_d[k] = octIn_d[k-1];
`endif
    end
  end

  // Write pointer names the next slot, which is also the oldest entry once the window is full
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q        <= '{default: '0};
      wrPtr_q      <= '{default: '0};
      decCnt_q     <= '0;
      octWritten_q <= '0;
      octFull_q    <= '0;
    end else begin
      octWritten_q <= fire_d;
      if (writeSample_i) begin
        decCnt_q <= decCnt_d;
      end
      for (int k = 0; k < OCT; k++) begin
        if (fire_d[k]) begin
          mem_q[k][wrPtr_q[k]] <= octIn_d[k];
          wrPtr_q[k]           <= wrPtr_q[k] + PW'(1);
          if (wrPtr_q[k] == PW'(DEPTH - 1)) begin
            octFull_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rdValid        = (int'(rdOctave_i) < OCT);
    rdIdx          = rdValid ? rdOctave_i : '0;
    rdPtr          = wrPtr_q[rdIdx];
    sample0_o      = rdValid ? mem_q[rdIdx][rdPtr - PW'(1)] : '0;
    sample1_o      = rdValid ? mem_q[rdIdx][rdPtr - PW'(2)] : '0;
    oldestSample_o = rdValid ? mem_q[rdIdx][rdPtr] : '0;
  end

  assign octWritten_o = octWritten_q;
  assign octFull_o    = octFull_q;

endmodule

// File: tb/tb_multi_octave_storage.sv
// Scoreboard bench for multi_octave_storage (OCT=3, DEPTH=4, N=16); expectations follow DECIMATE_AVG_EN.
module tb_multi_octave_storage;

`ifdef DECIMATE_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  typedef struct {
    logic [2:0]         ow;
    logic [2:0]         full;
    logic signed [15:0] s0;
    logic signed [15:0] s1;
    logic signed [15:0] old;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] newSample;
  logic               writeSample;
  logic [1:0]         rdOctave;
  logic signed [15:0] sample0, sample1, oldestSample;
  logic [2:0]         octWritten, octFull;
  bit                 probeReq;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  multi_octave_storage #(.N(16), .OCT(3), .DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .newSample_i    (newSample),
    .writeSample_i  (writeSample),
    .rdOctave_i     (rdOctave),
    .sample0_o      (sample0),
    .sample1_o      (sample1),
    .oldestSample_o (oldestSample),
    .octWritten_o   (octWritten),
    .octFull_o      (octFull)
  );

  task automatic cmpField(input string nm, input logic signed [31:0] act, input logic signed [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("octWritten", octWritten, e.ow);
    cmpField("octFull", octFull, e.full);
    cmpField("sample0", sample0, e.s0);
    cmpField("sample1", sample1, e.s1);
    cmpField("oldestSample", oldestSample, e.old);
  endtask

  // Monitor: a write shows up as an octWritten pulse; idle-cycle reads are flagged by probeReq
  always @(negedge clk) begin
    if (octWritten != 3'b000 || probeReq) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got octWritten=%b with no expectation, want none", octWritten);
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic [2:0] ow, input logic [2:0] full,
                            input logic signed [15:0] s0, input logic signed [15:0] s1,
                            input logic signed [15:0] old);
    exp_t e;
    e.ow = ow; e.full = full; e.s0 = s0; e.s1 = s1; e.old = old;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit wr, input logic signed [15:0] v, input logic [1:0] rd, input bit pb);
    writeSample = wr;
    newSample   = v;
    rdOctave    = rd;
    probeReq    = pb;
    tick();
  endtask

  task automatic writeVec(input logic signed [15:0] v, input logic [2:0] ow, input logic [2:0] full,
                          input logic signed [15:0] s0, input logic signed [15:0] s1,
                          input logic signed [15:0] old);
    pushExpect(ow, full, s0, s1, old);
    applyStimulus(1'b1, v, 2'd0, 1'b0);
  endtask

  task automatic probeVec(input logic [1:0] rd, input logic [2:0] ow, input logic [2:0] full,
                          input logic signed [15:0] s0, input logic signed [15:0] s1,
                          input logic signed [15:0] old);
    pushExpect(ow, full, s0, s1, old);
    applyStimulus(1'b0, 16'sd0, rd, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'sd0, 2'd0, 1'b0);
  endtask

  // Reset lands mid-cycle with a write pending across the edge; that write must be lost
  task automatic doReset();
    pushExpect(3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
    rst         = 1'b1;
    writeSample = 1'b1;
    newSample   = 16'sd999;
    rdOctave    = 2'd0;
    probeReq    = 1'b1;
    tick();
    rst         = 1'b0;
    writeSample = 1'b0;
    probeReq    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; writeSample = 1'b0; newSample = '0; rdOctave = '0; probeReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Partial fill, then reset mid-stream
    writeVec(16'sd5, 3'b001, 3'b000, 16'sd5, 16'sd0, 16'sd0);
    writeVec(16'sd6, 3'b011, 3'b000, 16'sd6, 16'sd5, 16'sd0);
    writeVec(16'sd7, 3'b001, 3'b000, 16'sd7, 16'sd6, 16'sd0);
    idle();
    doReset();

    // Octave-0 window fill and wrap, then decimated octaves
    writeVec(16'sd10, 3'b001, 3'b000, 16'sd10, 16'sd0,  16'sd0);
    writeVec(16'sd20, 3'b011, 3'b000, 16'sd20, 16'sd10, 16'sd0);
    writeVec(16'sd30, 3'b001, 3'b000, 16'sd30, 16'sd20, 16'sd0);
    writeVec(16'sd40, 3'b111, 3'b001, 16'sd40, 16'sd30, 16'sd10);
    writeVec(16'sd50, 3'b001, 3'b001, 16'sd50, 16'sd40, 16'sd20);
    idle();
    probeVec(2'd1, 3'b000, 3'b001, AVG ? 16'sd35 : 16'sd40, AVG ? 16'sd15 : 16'sd20, 16'sd0);
    probeVec(2'd2, 3'b000, 3'b001, AVG ? 16'sd25 : 16'sd40, 16'sd0, 16'sd0);
    probeVec(2'd3, 3'b000, 3'b001, 16'sd0, 16'sd0, 16'sd0);
    idle();
    doReset();

    // Firing schedule over a full counter period
    writeVec(16'sd1, 3'b001, 3'b000, 16'sd1, 16'sd0, 16'sd0);
    writeVec(16'sd2, 3'b011, 3'b000, 16'sd2, 16'sd1, 16'sd0);
    writeVec(16'sd3, 3'b001, 3'b000, 16'sd3, 16'sd2, 16'sd0);
    writeVec(16'sd4, 3'b111, 3'b001, 16'sd4, 16'sd3, 16'sd1);
    writeVec(16'sd5, 3'b001, 3'b001, 16'sd5, 16'sd4, 16'sd2);
    writeVec(16'sd6, 3'b011, 3'b001, 16'sd6, 16'sd5, 16'sd3);
    writeVec(16'sd7, 3'b001, 3'b001, 16'sd7, 16'sd6, 16'sd4);
    writeVec(16'sd8, 3'b111, 3'b011, 16'sd8, 16'sd7, 16'sd5);
    idle();
    probeVec(2'd0, 3'b000, 3'b011, 16'sd8, 16'sd7, 16'sd5);
    probeVec(2'd1, 3'b000, 3'b011, AVG ? 16'sd7 : 16'sd8, AVG ? 16'sd5 : 16'sd6, AVG ? 16'sd1 : 16'sd2);
    idle();
    doReset();

    // Averaging edges: rounding toward -inf and full-scale inputs
    writeVec(-16'sd3, 3'b001, 3'b000, -16'sd3, 16'sd0, 16'sd0);
    writeVec(16'sd0,  3'b011, 3'b000, 16'sd0, -16'sd3, 16'sd0);
    idle();
    probeVec(2'd1, 3'b000, 3'b000, AVG ? -16'sd2 : 16'sd0, 16'sd0, 16'sd0);
    idle();
    doReset();
    writeVec(16'sd32767, 3'b001, 3'b000, 16'sd32767, 16'sd0, 16'sd0);
    writeVec(16'sd32767, 3'b011, 3'b000, 16'sd32767, 16'sd32767, 16'sd0);
    idle();
    probeVec(2'd1, 3'b000, 3'b000, 16'sd32767, 16'sd0, 16'sd0);
    idle();
    doReset();
    writeVec(-16'sd32768, 3'b001, 3'b000, -16'sd32768, 16'sd0, 16'sd0);
    writeVec(-16'sd32768, 3'b011, 3'b000, -16'sd32768, -16'sd32768, 16'sd0);
    idle();
    probeVec(2'd1, 3'b000, 3'b000, -16'sd32768, 16'sd0, 16'sd0);
    idle();
    repeat (3) idle();

    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_drain: got %0d pending, want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_octave_storage.md
# multi_octave_storage

Multi-octave sample store for the octave DFT pipeline, replacing one single-octave storage instance per octave with one parametrised block. Every accepted audio sample goes into octave 0. Octave k receives a decimated sample on every 2^k-th write. Per octave, the block holds a DEPTH-entry circular window and exposes `sample0`, `sample1` and `oldestSample` for the octave the operation manager currently selects. It sits between the sample input and the bin accumulators.

## Interface
- `N`, 16: sample width, two's complement.
- `OCT`, 5: number of octaves, must be ≥ 2.
- `DEPTH`, 8: window length per octave, power of two, must be ≥ 2.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `newSample`  in  N  incoming octave-0 sample.
- `writeSample`  in  1  accept `newSample` on this edge; may be held high for back-to-back writes.
- `rdOctave`  in  $clog2(OCT)  octave whose window drives the read outputs.
- `sample0`  out  N  newest entry of `rdOctave`.
- `sample1`  out  N  second-newest entry of `rdOctave`.
- `oldestSample`  out  N  oldest entry in the DEPTH window of `rdOctave`, i.e. x[n−DEPTH+1].
- `octWritten`  out  OCT  registered one-cycle pulse; bit k set if octave k took a sample on the previous edge.
- `octFull`  out  OCT  level; bit k set once octave k has received ≥ DEPTH samples.

## Operation
- Storage: per octave, DEPTH×N entries plus a write pointer. All entries reset to 0, so unfilled slots read as 0.
- Write count: writes are numbered w = 1, 2, … since reset. A decimation counter of OCT−1 bits increments per accepted write and wraps at 2^(OCT−1).
- Octave k fires on write w iff w mod 2^k == 0. Octave 0 fires on every write.
- Octave 0 input is `newSample`.
- Octave k≥1 input is derived from octave k−1. Octave k−1 always fires on the same write, so the derivation uses its value being written this cycle (v_new) and its current newest entry (v_prev).
- With averaging (see Configuration), the input is (v_prev + v_new) >>> 1. The sum is computed at N+1 bits, then arithmetically shifted. Rounding is toward −inf and the result cannot overflow.
- The derivation chains combinationally through all fired octaves within one cycle.
- Read outputs are combinational from stored state and `rdOctave`. A `rdOctave` value ≥ OCT reads all zeros.
- `octFull[k]` sets on the DEPTH-th write to octave k and stays set until reset.
- `writeSample` low: no state change, and `octWritten` is 0 next cycle.

## Timing
- Write latency: new contents are visible on `sample0`/`sample1`/`oldestSample` immediately after the capturing edge, in the same cycle `octWritten` pulses.
- `rdOctave` changes take effect combinationally. A change coincident with a write reads pre-edge contents until the edge.
- Reset is asserted asynchronously:
  - all outputs are immediately 0;
  - pointers, decimation counter and `octFull` are cleared;
  - a write in flight is discarded.
- After reset deasserts, the next write is w = 1.
- Counter wrap: the write with w mod 2^(OCT−1) == 0 fires all octaves, then the pattern repeats.
- Pointer wrap: the write after the window is full overwrites the oldest slot, and `oldestSample` advances by one.

## Configuration
- `DECIMATE_AVG_EN` defined: octave k≥1 input is the two-sample average described above.
- Not defined: octave k≥1 input is v_new (pure drop-decimation), with no adder logic. The firing schedule is identical.

## Test plan
All scenarios use OCT=3, DEPTH=4, N=16 unless noted.
- Reset check: reset during idle and again mid-stream after 3 writes. Required: all outputs 0, `octWritten`=000, `octFull`=000; the next write produces `octWritten`=001.
- Octave-0 window: write 10, 20, 30, 40 back-to-back, `rdOctave`=0. Required: `sample0`=40, `sample1`=30, `oldestSample`=10, `octFull`=001. Then write 50. Required: `oldestSample`=20.
- Decimation with `DECIMATE_AVG_EN`: after the writes 10, 20, 30, 40:
  - `rdOctave`=1 gives `sample0`=35, `sample1`=15;
  - `rdOctave`=2 gives `sample0`=25.
- Decimation without the macro: same stimulus. Required: octave 1 shows 40/20 and octave 2 shows 40.
- Schedule: 8 continuous writes. Required: `octWritten` sequence 001, 011, 001, 111, 001, 011, 001, 111. One idle cycle with `writeSample` low gives 000.
- Arithmetic edges, with averaging: writes −3, 0. Required: octave 1 `sample0`=−2. Writes 32767, 32767. Required: 32767. Writes −32768, −32768. Required: −32768.
